ula_reg_arbiter: RTL and testbench
==================================

ULA_REG_ARBITER -- requirements
Module: ula_reg_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of WAIT cycles for valid_out; legal range 2..255.
REQ-002 SHALL have port clk_ula  in  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports reqK_valid (K=0,1)  in  1  requester K holds a command.
REQ-005 SHALL have ports reqK_ready  out  1  command from requester K is accepted this cycle.
REQ-006 SHALL have ports reqK_kind  in  1  command kind: 0=register write, 1=ULA operation.
REQ-007 SHALL have ports reqK_A and reqK_data  in  16 each  operand A and write data.
REQ-008 SHALL have ports reqK_addr, reqK_sel, reqK_instru  in  2 each  write address, register select, ULA instruction.
REQ-009 SHALL have ports rspK_valid  out  1  one-cycle response strobe to requester K.
REQ-010 SHALL have ports rspK_data  out  32  and rspK_err  out  1  result and timeout flag.
REQ-011 SHALL have ports valid_reg and valid_ula  out  1 each  one-cycle issue strobes to the datapath.
REQ-012 SHALL have ports A and data_in  out  16 each, plus addr, reg_sel, instru  out  2 each  datapath command fields.
REQ-013 SHALL have ports data_out  in  32  and valid_out  in  1  datapath result and result strobe.
REQ-014 SHALL have ports busy  out  1  FSM not in IDLE, and spurious  out  1  sticky flag for valid_out seen outside WAIT.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; the state and all outputs except reqK_ready and busy SHALL be registered.
REQ-016 SHALL arbitrate in IDLE only; with a single reqK_valid, K is granted; with both valid, the requester not equal to last_grant is granted (round-robin).
REQ-017 SHALL drive reqK_ready=1 combinationally only in IDLE for the granted K; a transfer is reqK_valid&reqK_ready; on transfer capture all K fields plus grant index, then go IDLE->ISSUE.
REQ-018 SHALL in ISSUE pulse valid_reg (kind 0) or valid_ula (kind 1) for exactly one cycle; A, data_in, addr, reg_sel, instru SHALL take captured values at ISSUE and hold them until the next ISSUE.
REQ-019 SHALL go ISSUE->RESP for kind 0 (rsp data=0, err=0) and ISSUE->WAIT for kind 1, clearing the 8-bit wait counter.
REQ-020 SHALL in WAIT on valid_out=1 capture data_out and go to RESP with err=0; otherwise increment the counter; when the counter equals TIMEOUT-1 without valid_out, go to RESP with data=0 and err=1.
REQ-021 SHALL give valid_out priority over timeout when both occur in the same cycle.
REQ-022 SHALL in RESP assert rspK_valid for one cycle to the granted K only, with rspK_data/rspK_err valid that cycle; last_grant<=K; RESP->IDLE. Responses have no backpressure.
REQ-023 SHALL keep rspK_data/rspK_err at last values when rspK_valid=0.
REQ-024 SHALL latency: write accepted at cycle T -> rsp at T+2; op accepted at T with valid_out at T+2+n -> rsp at T+3+n; timeout rsp at T+2+TIMEOUT.
REQ-025 SHALL set spurious=1 on valid_out=1 in IDLE, ISSUE or RESP and ignore that data; spurious clears only on reset.
REQ-026 SHALL not accept a new command before RESP completes (one command in flight); min accept-to-accept spacing 3 cycles.

Reset
REQ-027 SHALL on rst=0, immediately and regardless of clock: state=IDLE, all strobes, ready, rsp outputs, datapath fields, counter, busy, spurious =0; last_grant=1 (requester 0 wins first tie).
REQ-028 SHALL abort any in-flight command on reset mid-operation with no response issued; a valid_out arriving after reset release sets spurious.

Verification
REQ-029 SHALL cover: req0 write addr=2 data=0x00A5 at T -> valid_reg=1 at T+1 with addr=2,data_in=0x00A5; rsp0_valid at T+2, data=0, err=0.
REQ-030 SHALL cover: req1 op A=0x0003 sel=1 instru=2, valid_out with data_out=0x0000_1234 two cycles after valid_ula -> rsp1_data=0x0000_1234, err=0.
REQ-031 SHALL cover: both requesters valid from reset for 4 commands -> grant order 0,1,0,1.
REQ-032 SHALL cover: op with no valid_out, TIMEOUT=15 -> rsp err=1, data=0, rsp exactly 15 cycles after ISSUE+1; valid_out on last WAIT cycle -> err=0.
REQ-033 SHALL cover: rst low during WAIT -> all outputs 0 asynchronously, no rsp; valid_out after release -> spurious=1.

Source files
------------

// File: rtl/ula_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ula_reg_arbiter
// Brief   : Round-robin front end that serialises register writes and ULA ops
//           from two requesters onto one datapath, one command in flight.
// Revision: 1.0 - initial release
// ============================================================================
module ula_reg_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk_ula,
  input  logic        rst,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_kind,
  input  logic [15:0] req0_A,
  input  logic [15:0] req0_data,
  input  logic [1:0]  req0_addr,
  input  logic [1:0]  req0_sel,
  input  logic [1:0]  req0_instru,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_data,
  output logic        rsp0_err,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_kind,
  input  logic [15:0] req1_A,
  input  logic [15:0] req1_data,
  input  logic [1:0]  req1_addr,
  input  logic [1:0]  req1_sel,
  input  logic [1:0]  req1_instru,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_data,
  output logic        rsp1_err,

  output logic        valid_reg,
  output logic        valid_ula,
  output logic [15:0] A,
  output logic [15:0] data_in,
  output logic [1:0]  addr,
  output logic [1:0]  reg_sel,
  output logic [1:0]  instru,
  input  logic [31:0] data_out,
  input  logic        valid_out,

  output logic        busy,
  output logic        spurious
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic        r_last_grant;
  logic        r_grant;
  logic        r_kind;
  logic [7:0]  r_cnt;

  logic        w_any;
  logic        w_grant;
  logic        w_done;
  logic [31:0] w_rsp_data;
  logic        w_rsp_err;

  assign w_any   = req0_valid | req1_valid;
  // On a tie the requester that did not win last time goes first.
  assign w_grant = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;

  assign req0_ready = rst & (r_state == ST_IDLE) & req0_valid & ~w_grant;
  assign req1_ready = rst & (r_state == ST_IDLE) & req1_valid &  w_grant;
  assign busy       = (r_state != ST_IDLE);

  // Writes finish straight out of ISSUE; ops finish on result or timeout,
  // with the result winning when both land in the same cycle.
  assign w_done     = ((r_state == ST_ISSUE) & ~r_kind) |
                      ((r_state == ST_WAIT) & (valid_out | (r_cnt == c_cnt_last)));
  assign w_rsp_data = ((r_state == ST_WAIT) & valid_out) ? data_out : 32'd0;
  assign w_rsp_err  = (r_state == ST_WAIT) & ~valid_out;

  always_ff @(posedge clk_ula or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_kind       <= 1'b0;
      r_cnt        <= 8'd0;
      valid_reg    <= 1'b0;
      valid_ula    <= 1'b0;
      A            <= 16'd0;
      data_in      <= 16'd0;
      addr         <= 2'd0;
      reg_sel      <= 2'd0;
      instru       <= 2'd0;
      rsp0_valid   <= 1'b0;
      rsp0_data    <= 32'd0;
      rsp0_err     <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp1_data    <= 32'd0;
      rsp1_err     <= 1'b0;
      spurious     <= 1'b0;
    end else begin
      valid_reg  <= 1'b0;
      valid_ula  <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;

      if (valid_out && (r_state != ST_WAIT)) begin
        spurious <= 1'b1;
      end

      if (w_done) begin
        r_state <= ST_RESP;
        if (r_grant) begin
          rsp1_valid <= 1'b1;
          rsp1_data  <= w_rsp_data;
          rsp1_err   <= w_rsp_err;
        end else begin
          rsp0_valid <= 1'b1;
          rsp0_data  <= w_rsp_data;
          rsp0_err   <= w_rsp_err;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_any) begin
              r_grant <= w_grant;
              r_state <= ST_ISSUE;
              if (w_grant) begin
                r_kind    <= req1_kind;
                A         <= req1_A;
                data_in   <= req1_data;
                addr      <= req1_addr;
                reg_sel   <= req1_sel;
                instru    <= req1_instru;
                valid_reg <= ~req1_kind;
                valid_ula <= req1_kind;
              end else begin
                r_kind    <= req0_kind;
                A         <= req0_A;
                data_in   <= req0_data;
                addr      <= req0_addr;
                reg_sel   <= req0_sel;
                instru    <= req0_instru;
                valid_reg <= ~req0_kind;
                valid_ula <= req0_kind;
              end
            end
          end
          ST_ISSUE: begin
            r_cnt   <= 8'd0;
            r_state <= ST_WAIT;
          end
          ST_WAIT: begin
            r_cnt <= r_cnt + 8'd1;
          end
          ST_RESP: begin
            r_last_grant <= r_grant;
            r_state      <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ula_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_ula_reg_arbiter
// Brief   : Transaction-level reference bench for ula_reg_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ula_reg_arbiter;

  localparam int TIMEOUT = 15;

  typedef struct packed {
    logic        kind;
    logic [15:0] a;
    logic [15:0] data;
    logic [1:0]  addr;
    logic [1:0]  sel;
    logic [1:0]  instru;
  } cmd_t;

  logic        clk_ula = 1'b0;
  logic        rst     = 1'b0;
  logic        req0_valid, req0_ready, req0_kind;
  logic [15:0] req0_A, req0_data;
  logic [1:0]  req0_addr, req0_sel, req0_instru;
  logic        rsp0_valid, rsp0_err;
  logic [31:0] rsp0_data;
  logic        req1_valid, req1_ready, req1_kind;
  logic [15:0] req1_A, req1_data;
  logic [1:0]  req1_addr, req1_sel, req1_instru;
  logic        rsp1_valid, rsp1_err;
  logic [31:0] rsp1_data;
  logic        valid_reg, valid_ula;
  logic [15:0] A, data_in;
  logic [1:0]  addr, reg_sel, instru;
  logic [31:0] data_out;
  logic        valid_out;
  logic        busy, spurious;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic        m_last;
  logic [31:0] m_data [2];
  logic        m_err  [2];

  always #5 clk_ula = ~clk_ula;

  ula_reg_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk_ula(clk_ula), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_kind(req0_kind),
    .req0_A(req0_A), .req0_data(req0_data), .req0_addr(req0_addr),
    .req0_sel(req0_sel), .req0_instru(req0_instru),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_kind(req1_kind),
    .req1_A(req1_A), .req1_data(req1_data), .req1_addr(req1_addr),
    .req1_sel(req1_sel), .req1_instru(req1_instru),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .valid_reg(valid_reg), .valid_ula(valid_ula), .A(A), .data_in(data_in),
    .addr(addr), .reg_sel(reg_sel), .instru(instru),
    .data_out(data_out), .valid_out(valid_out),
    .busy(busy), .spurious(spurious)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t mk(input logic kind, input logic [15:0] a, input logic [15:0] d,
                              input logic [1:0] ad, input logic [1:0] s, input logic [1:0] ins);
    cmd_t c;
    c.kind = kind; c.a = a; c.data = d; c.addr = ad; c.sel = s; c.instru = ins;
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    return mk(1'($urandom), 16'($urandom), 16'($urandom),
              2'($urandom), 2'($urandom), 2'($urandom));
  endfunction

  task automatic drive_req(input int k, input logic v, input cmd_t c);
    if (k == 0) begin
      req0_valid = v; req0_kind = c.kind; req0_A = c.a; req0_data = c.data;
      req0_addr = c.addr; req0_sel = c.sel; req0_instru = c.instru;
    end else begin
      req1_valid = v; req1_kind = c.kind; req1_A = c.a; req1_data = c.data;
      req1_addr = c.addr; req1_sel = c.sel; req1_instru = c.instru;
    end
  endtask

  // One full command from the IDLE negedge to the IDLE negedge after RESP.
  // n: cycles after WAIT entry that valid_out arrives, or -1 for none.
  task automatic run_cmd(input logic v0, input logic v1, input cmd_t c0, input cmd_t c1,
                         input int n, input logic [31:0] dout);
    logic        g;
    cmd_t        c;
    int          lat;
    logic [31:0] ed;
    logic        ee;
    g = (v0 && v1) ? ~m_last : v1;
    c = g ? c1 : c0;
    drive_req(0, v0, c0);
    drive_req(1, v1, c1);
    #1;
    chk("ready0", 32'(req0_ready), 32'(!g));
    chk("ready1", 32'(req1_ready), 32'(g));
    chk("busy_idle", 32'(busy), 32'd0);
    @(posedge clk_ula);
    @(negedge clk_ula);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("valid_reg", 32'(valid_reg), 32'(!c.kind));
    chk("valid_ula", 32'(valid_ula), 32'(c.kind));
    chk("A", 32'(A), 32'(c.a));
    chk("data_in", 32'(data_in), 32'(c.data));
    chk("addr", 32'(addr), 32'(c.addr));
    chk("reg_sel", 32'(reg_sel), 32'(c.sel));
    chk("instru", 32'(instru), 32'(c.instru));
    chk("busy_issue", 32'(busy), 32'd1);
    if (!c.kind) begin
      lat = 2; ed = 32'd0; ee = 1'b0;
    end else if (n >= 0) begin
      lat = 3 + n; ed = dout; ee = 1'b0;
    end else begin
      lat = 2 + TIMEOUT; ed = 32'd0; ee = 1'b1;
    end
    for (int cyc = 2; cyc <= lat; cyc++) begin
      @(negedge clk_ula);
      if (c.kind && (n >= 0) && (cyc == 2 + n)) begin
        valid_out = 1'b1; data_out = dout;
      end else begin
        valid_out = 1'b0; data_out = $urandom;
      end
      if (cyc < lat) begin
        chk("no_early_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
        chk("no_restrobe", 32'({valid_reg, valid_ula}), 32'd0);
      end else begin
        chk("rsp_valid_g", 32'(g ? rsp1_valid : rsp0_valid), 32'd1);
        chk("rsp_valid_other", 32'(g ? rsp0_valid : rsp1_valid), 32'd0);
        chk("rsp_data", g ? rsp1_data : rsp0_data, ed);
        chk("rsp_err", 32'(g ? rsp1_err : rsp0_err), 32'(ee));
        chk("other_data_held", g ? rsp0_data : rsp1_data, m_data[!g]);
      end
    end
    m_data[g] = ed;
    m_err[g]  = ee;
    m_last    = g;
    @(negedge clk_ula);
    valid_out = 1'b0;
    chk("rsp_one_cycle", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    chk("rsp0_hold", rsp0_data, m_data[0]);
    chk("rsp1_hold", rsp1_data, m_data[1]);
    chk("err_hold", 32'({rsp0_err, rsp1_err}), 32'({m_err[0], m_err[1]}));
    chk("busy_back_idle", 32'(busy), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_strobes"}, 32'({valid_reg, valid_ula, rsp0_valid, rsp1_valid}), 32'd0);
    chk({tag, "_ready"}, 32'({req0_ready, req1_ready}), 32'd0);
    chk({tag, "_rspdata"}, rsp0_data | rsp1_data, 32'd0);
    chk({tag, "_rsperr"}, 32'({rsp0_err, rsp1_err}), 32'd0);
    chk({tag, "_fields"}, {A, data_in} | 32'({addr, reg_sel, instru}), 32'd0);
    chk({tag, "_busy_spur"}, 32'({busy, spurious}), 32'd0);
  endtask

  initial begin
    int   r;
    logic v0, v1;
    m_last = 1'b1;
    m_data[0] = 32'd0; m_data[1] = 32'd0;
    m_err[0]  = 1'b0;  m_err[1]  = 1'b0;
    drive_req(0, 1'b0, mk(1'b0, 16'd0, 16'd0, 2'd0, 2'd0, 2'd0));
    drive_req(1, 1'b0, mk(1'b0, 16'd0, 16'd0, 2'd0, 2'd0, 2'd0));
    valid_out = 1'b0;
    data_out  = 32'd0;

    // Reset state, including ready held low while both requesters wait.
    @(negedge clk_ula);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk_all_zero("reset");
    @(negedge clk_ula);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk_ula);

    // Both valid from reset: grants must alternate 0,1,0,1.
    for (int i = 0; i < 4; i++) begin
      run_cmd(1'b1, 1'b1, rand_cmd(), rand_cmd(), $urandom_range(0, 3), $urandom);
      chk("tie_order", 32'(m_last), 32'(i % 2));
    end

    // Register write from requester 0.
    run_cmd(1'b1, 1'b0, mk(1'b0, 16'h1111, 16'h00A5, 2'd2, 2'd0, 2'd0), rand_cmd(), 0, 32'd0);
    // ULA op from requester 1, result two cycles after the issue strobe.
    run_cmd(1'b0, 1'b1, rand_cmd(), mk(1'b1, 16'h0003, 16'h0000, 2'd0, 2'd1, 2'd2), 1, 32'h0000_1234);
    // Timeout with no result, then result on the very last WAIT cycle.
    run_cmd(1'b1, 1'b0, mk(1'b1, 16'h0042, 16'h0007, 2'd1, 2'd3, 2'd1), rand_cmd(), -1, 32'd0);
    run_cmd(1'b0, 1'b1, rand_cmd(), mk(1'b1, 16'h00FF, 16'h0001, 2'd3, 2'd2, 2'd3),
            TIMEOUT - 1, 32'hCAFE_F00D);
    run_cmd(1'b0, 1'b1, rand_cmd(), mk(1'b1, 16'h0001, 16'h0002, 2'd0, 2'd0, 2'd0), 0, 32'h8000_0001);

    // Randomised traffic.
    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(1, 3);
      v0 = r[0];
      v1 = r[1];
      run_cmd(v0, v1, rand_cmd(), rand_cmd(), int'($urandom_range(0, TIMEOUT)) - 1, $urandom);
    end
    chk("spurious_clean", 32'(spurious), 32'd0);

    // Stray result while idle.
    valid_out = 1'b1; data_out = 32'hDEAD_BEEF;
    @(negedge clk_ula);
    valid_out = 1'b0;
    chk("spurious_idle", 32'(spurious), 32'd1);
    chk("spurious_no_rsp", 32'({rsp0_valid, rsp1_valid, busy}), 32'd0);
    chk("spurious_data_ignored", rsp0_data, m_data[0]);

    // Reset in the middle of WAIT aborts the op with no response.
    drive_req(0, 1'b1, mk(1'b1, 16'h5A5A, 16'h0F0F, 2'd1, 2'd2, 2'd3));
    @(posedge clk_ula);
    @(negedge clk_ula);
    req0_valid = 1'b0;
    @(negedge clk_ula);
    chk("in_wait_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk_all_zero("async_reset");
    m_last = 1'b1;
    m_data[0] = 32'd0; m_data[1] = 32'd0;
    m_err[0]  = 1'b0;  m_err[1]  = 1'b0;
    @(negedge clk_ula);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_ula);
      chk("no_rsp_after_abort", 32'({rsp0_valid, rsp1_valid, busy}), 32'd0);
    end
    valid_out = 1'b1; data_out = 32'h0000_7777;
    @(negedge clk_ula);
    valid_out = 1'b0;
    chk("late_result_spurious", 32'(spurious), 32'd1);
    chk("late_result_no_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);

    // After reset the first tie goes to requester 0 again.
    run_cmd(1'b1, 1'b1, rand_cmd(), rand_cmd(), 2, $urandom);
    chk("tie_after_reset", 32'(m_last), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
